// File: rtl/mult_secuencial.sv
// Sequential signed fixed-point multiplier (shift-add, one partial product per clock).
// Operands are Q(ent).(frac) two's complement. The full double-width product is
// Q(2*ent).(2*frac), with no rounding or saturation.
module mult_secuencial #(
  parameter int unsigned cant_bits = 16,
  parameter int unsigned ent       = 9,
  parameter int unsigned frac      = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [cant_bits-1:0]       a,
  input  logic [cant_bits-1:0]       b,
  output logic                       busy,
  output logic                       done,
  output logic [2*cant_bits-1:0]     producto
);

  localparam int unsigned W2 = 2 * cant_bits;
  localparam int unsigned CW = (cant_bits > 1) ? $clog2(cant_bits) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [cant_bits-1:0] mcand, mcand_nxt;
  logic [cant_bits-1:0] mplier, mplier_nxt;
  logic [W2-1:0]        acc, acc_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 sig, sig_nxt;
  logic                 busy_nxt, done_nxt;
  logic [W2-1:0]        producto_nxt;
  logic [cant_bits:0]   sum;

  // Upper accumulator half plus multiplicand; the extra bit holds the carry.
  always_comb begin
    sum = {1'b0, acc[W2-1:cant_bits]} + {1'b0, mcand};
  end

  // Next-state and next-register logic.
  always_comb begin
    state_nxt    = state;
    mcand_nxt    = mcand;
    mplier_nxt   = mplier;
    acc_nxt      = acc;
    cnt_nxt      = cnt;
    sig_nxt      = sig;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    producto_nxt = producto;

    unique case (state)
      IDLE: begin
        if (start) begin
          // Magnitudes are unsigned, so |-2^(cant_bits-1)| is exact.
          mcand_nxt  = a[cant_bits-1] ? -a : a;
          mplier_nxt = b[cant_bits-1] ? -b : b;
          sig_nxt    = a[cant_bits-1] ^ b[cant_bits-1];
          acc_nxt    = '0;
          cnt_nxt    = '0;
          busy_nxt   = 1'b1;
          state_nxt  = CALC;
        end
      end
      CALC: begin
        if (mplier[0]) begin
          acc_nxt = {sum, acc[cant_bits-1:1]};
        end else begin
          acc_nxt = {1'b0, acc[W2-1:1]};
        end
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + CW'(1);
        // ent + frac equals cant_bits: one CALC edge per operand bit.
        if (cnt == CW'(ent + frac - 1)) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        producto_nxt = sig ? -acc : acc;
        done_nxt     = 1'b1;
        busy_nxt     = 1'b0;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      sig      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      producto <= '0;
    end else begin
      state    <= state_nxt;
      mcand    <= mcand_nxt;
      mplier   <= mplier_nxt;
      acc      <= acc_nxt;
      cnt      <= cnt_nxt;
      sig      <= sig_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      producto <= producto_nxt;
    end
  end

endmodule

// File: tb/tb_mult_secuencial.sv
// Testbench for mult_secuencial: directed and random multiplies against a signed
// arithmetic reference model, plus handshake, latency and reset checks.
module tb_mult_secuencial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [31:0] producto;

  int total  = 0;
  int passed = 0;
  int nfail  = 0;
  logic [31:0] last_prod;

  mult_secuencial #(.cant_bits(16), .ent(9), .frac(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .producto(producto)
  );

  always #5 clk = ~clk;

  // Reference: plain signed multiply of the Q9.7 operands gives the Q18.14 product.
  function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return 32'(p);
  endfunction

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) passed++;
    else begin
      nfail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the negedge after the accepted start edge; ends in the done cycle.
  task automatic run_to_done(input logic [31:0] exp, input string tag, input int poke);
    int n;
    bit busy_ok, hold_ok;
    n = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (producto !== last_prod) hold_ok = 1'b0;
      if (n == poke) begin
        start = 1'b1; a = 16'($urandom); b = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk(32'(n), 32'd17, {tag, "_latency"});
    chk(32'(busy_ok), 32'd1, {tag, "_busy_high"});
    chk(32'(hold_ok), 32'd1, {tag, "_prod_held"});
    chk(32'(busy), 32'd0, {tag, "_busy_fall"});
    chk(producto, exp, {tag, "_producto"});
    last_prod = exp;
  endtask

  task automatic mult(input logic [15:0] x, input logic [15:0] y, input string tag, input int poke);
    logic [31:0] exp;
    exp = ref_prod(x, y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    run_to_done(exp, tag, poke);
    @(negedge clk);
    chk(32'(done), 32'd0, {tag, "_done_pulse"});
  endtask

  initial begin
    bit no_done;
    logic [31:0] e1, e2;

    // Reset with start held high.
    rst_n = 1'b0; start = 1'b1; a = 16'h00C0; b = 16'h0100;
    last_prod = '0;
    repeat (3) @(negedge clk);
    chk(32'(busy), 32'd0, "rst_busy");
    chk(32'(done), 32'd0, "rst_done");
    chk(producto, 32'h0, "rst_producto");
    rst_n = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    chk(32'(busy), 32'd0, "idle_busy");
    chk(producto, 32'h0, "idle_producto");

    // Directed values, including extremes.
    mult(16'h00C0, 16'h0100, "m_1p5x2", -1);
    chk(producto, 32'h0000C000, "m_1p5x2_const");
    mult(16'hFF80, 16'h0080, "m_neg1x1", -1);
    chk(producto, 32'hFFFFC000, "m_neg1x1_const");
    mult(16'h0000, 16'h8000, "m_zero", -1);
    chk(producto, 32'h00000000, "m_zero_const");
    mult(16'h8000, 16'h8000, "m_minxmin", -1);
    chk(producto, 32'h40000000, "m_minxmin_const");
    mult(16'h7FFF, 16'h7FFF, "m_maxxmax", -1);
    chk(producto, 32'h3FFF0001, "m_maxxmax_const");
    mult(16'h8000, 16'h7FFF, "m_minxmax", -1);
    chk(producto, 32'hC0008000, "m_minxmax_const");
    mult(16'hFFFF, 16'h0000, "m_negzero", -1);

    // start pulsed during busy with different operands is ignored.
    mult(16'h0123, 16'hFEDC, "m_ignore", 5);

    // Random operands.
    for (int i = 0; i < 12; i++) begin
      mult(16'($urandom), 16'($urandom), $sformatf("rnd%0d", i), (i % 3 == 0) ? 9 : -1);
    end

    // Back-to-back: start accepted in the done cycle.
    e1 = ref_prod(16'h1234, 16'hF00D);
    e2 = ref_prod(16'hA5A5, 16'h0F0F);
    @(negedge clk);
    a = 16'h1234; b = 16'hF00D; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    run_to_done(e1, "b2b_first", -1);
    a = 16'hA5A5; b = 16'h0F0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    run_to_done(e2, "b2b_second", -1);
    @(negedge clk);
    chk(32'(done), 32'd0, "b2b_done_pulse");

    // Reset in the middle of a multiply.
    @(negedge clk);
    a = 16'h3333; b = 16'h4444; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(32'(busy), 32'd0, "midrst_busy");
    chk(32'(done), 32'd0, "midrst_done");
    chk(producto, 32'h0, "midrst_producto");
    @(negedge clk);
    rst_n = 1'b1;
    last_prod = '0;
    no_done = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
    end
    chk(32'(no_done), 32'd1, "midrst_no_done");
    mult(16'hFF00, 16'h0280, "after_rst", -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
